// File: rtl/sync_fifo_wrctrl_gen_if.sv
// Write-side bus of the FIFO controller: the upstream request plus the RAM write port.
interface sync_fifo_wrctrl_gen_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32
);
    logic          wenable;
    logic [DW-1:0] wdata_i;
    logic          wenable_o;
    logic [DW-1:0] wdata_o;
    logic [AW-1:0] waddr_o;

    modport master (
        output wenable,
        output wdata_i,
        input  wenable_o,
        input  wdata_o,
        input  waddr_o
    );

    modport slave (
        input  wenable,
        input  wdata_i,
        output wenable_o,
        output wdata_o,
        output waddr_o
    );
endinterface

// File: rtl/sync_fifo_wrctrl_gen.sv
// Write-side controller for a single-clock FIFO: wrap-tagged write pointer, level and
// almost-full flags, sticky overflow with a saturating drop counter.
module sync_fifo_wrctrl_gen #(
    parameter int unsigned AW  = 7,
    parameter int unsigned DW  = 32,
    parameter int unsigned OCW = 8
) (
    input  logic                   wclk_i,
    input  logic                   rst_n,
    sync_fifo_wrctrl_gen_if.slave  wr_if,
    input  logic [AW:0]            rpnt_i,
    input  logic [AW:0]            afull_thr_i,
    input  logic                   ovf_clr_i,
    output logic [AW:0]            wpnt_o,
    output logic                   full_o,
    output logic                   afull_o,
    output logic [AW:0]            level_o,
    output logic                   ovf_o,
    output logic [OCW-1:0]         ovf_cnt_o
);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]  wpnt_q, wpnt_d;
    logic           ovf_q, ovf_d;
    logic [OCW-1:0] ovf_cnt_q, ovf_cnt_d;
    logic           full;
    logic           accept;
    logic           drop;

    // Flags are combinational from the pointer pair so they never lag a read.
    always_comb begin
        level_o = wpnt_q - rpnt_i;
        full    = (wpnt_q[AW] != rpnt_i[AW]) && (wpnt_q[AW-1:0] == rpnt_i[AW-1:0]);
        afull_o = (level_o >= afull_thr_i);
        full_o  = full;
        accept  = rst_n & wr_if.wenable & ~full;
        drop    = rst_n & wr_if.wenable & full;
    end

    assign wr_if.wenable_o = accept;
    assign wr_if.wdata_o   = wr_if.wdata_i;
    assign wr_if.waddr_o   = wpnt_q[AW-1:0];
    assign wpnt_o          = wpnt_q;
    assign ovf_o           = ovf_q;
    assign ovf_cnt_o       = ovf_cnt_q;

    // Next state; a drop on the same edge as a clear wins and restarts the count at one.
    always_comb begin
        wpnt_d    = wpnt_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (accept) begin
            wpnt_d = wpnt_q + PW'(1);
        end
        if (ovf_clr_i) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr_i) begin
                ovf_cnt_d = OCW'(1);
            end else if (!(&ovf_cnt_q)) begin
                ovf_cnt_d = ovf_cnt_q + OCW'(1);
            end
        end
    end

    always_ff @(posedge wclk_i) begin
        if (!rst_n) begin
            wpnt_q    <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            wpnt_q    <= wpnt_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end
endmodule

// File: tb/tb_sync_fifo_wrctrl_gen.sv
// Directed bench for sync_fifo_wrctrl_gen at AW=3/DW=8, with an OCW=2 twin for saturation.
module tb_sync_fifo_wrctrl_gen;
    logic       clk;
    logic       rst_n;
    logic [3:0] rpnt;
    logic [3:0] thr;
    logic       clr;

    logic [3:0] wpnt_a, lvl_a, wpnt_b, lvl_b;
    logic       full_a, afull_a, ovf_a, full_b, afull_b, ovf_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int total = 0;
    int bad   = 0;

    sync_fifo_wrctrl_gen_if #(.AW(3), .DW(8)) ifa ();
    sync_fifo_wrctrl_gen_if #(.AW(3), .DW(8)) ifb ();

    assign ifb.wenable = ifa.wenable;
    assign ifb.wdata_i = ifa.wdata_i;

    sync_fifo_wrctrl_gen #(.AW(3), .DW(8), .OCW(8)) dut_a (
        .wclk_i(clk), .rst_n(rst_n), .wr_if(ifa.slave), .rpnt_i(rpnt), .afull_thr_i(thr),
        .ovf_clr_i(clr), .wpnt_o(wpnt_a), .full_o(full_a), .afull_o(afull_a),
        .level_o(lvl_a), .ovf_o(ovf_a), .ovf_cnt_o(cnt_a)
    );

    sync_fifo_wrctrl_gen #(.AW(3), .DW(8), .OCW(2)) dut_b (
        .wclk_i(clk), .rst_n(rst_n), .wr_if(ifb.slave), .rpnt_i(rpnt), .afull_thr_i(thr),
        .ovf_clr_i(clr), .wpnt_o(wpnt_b), .full_o(full_b), .afull_o(afull_b),
        .level_o(lvl_b), .ovf_o(ovf_b), .ovf_cnt_o(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst_n;
        logic       wen;
        logic       clr;
        logic [3:0] thr;
        logic       e_wen;
        logic [2:0] e_addr;
        logic [3:0] e_wpnt;
        logic [3:0] e_lvl;
        logic       e_full;
        logic       e_afull;
        logic       e_ovf;
        logic [7:0] e_cnt;
        logic [1:0] e_cnt2;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic c, input logic [3:0] t,
                       input logic ew, input logic [2:0] ea, input logic [3:0] ep,
                       input logic [3:0] el, input logic ef, input logic eaf,
                       input logic eo, input logic [7:0] ec, input logic [1:0] ec2);
        vec_t v;
        v = '{r, w, c, t, ew, ea, ep, el, ef, eaf, eo, ec, ec2};
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] wp, rp, lvl;
    logic       we, ewen, seen_wrap;
    int         acc, cyc_n;
    logic [7:0] wd;

    initial begin
        rst_n = 1'b0; rpnt = '0; thr = 4'd6; clr = 1'b0;
        ifa.wenable = 1'b0; ifa.wdata_i = '0;

        // Pre-edge expectations; state changes land on the following edge.
        add(1, 0, 0, 6,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(1, 1, 0, 6, 1, 3'(k), 4'(k), 4'(k), 0, (k >= 6), 0, 0, 0);
        add(1, 1, 0, 6,  0, 0, 8, 8, 1, 1, 0, 0, 0);
        add(1, 1, 0, 6,  0, 0, 8, 8, 1, 1, 1, 1, 1);
        add(1, 1, 0, 6,  0, 0, 8, 8, 1, 1, 1, 2, 2);
        add(1, 0, 0, 6,  0, 0, 8, 8, 1, 1, 1, 3, 3);
        add(1, 0, 1, 6,  0, 0, 8, 8, 1, 1, 1, 3, 3);
        add(1, 0, 0, 6,  0, 0, 8, 8, 1, 1, 0, 0, 0);
        add(1, 1, 1, 6,  0, 0, 8, 8, 1, 1, 0, 0, 0);
        add(1, 1, 0, 6,  0, 0, 8, 8, 1, 1, 1, 1, 1);
        add(1, 1, 0, 6,  0, 0, 8, 8, 1, 1, 1, 2, 2);
        add(1, 1, 0, 6,  0, 0, 8, 8, 1, 1, 1, 3, 3);
        add(1, 1, 0, 6,  0, 0, 8, 8, 1, 1, 1, 4, 3);
        add(1, 0, 0, 6,  0, 0, 8, 8, 1, 1, 1, 5, 3);
        add(1, 0, 0, 9,  0, 0, 8, 8, 1, 0, 1, 5, 3);
        add(1, 0, 1, 6,  0, 0, 8, 8, 1, 1, 1, 5, 3);
        add(1, 0, 0, 6,  0, 0, 8, 8, 1, 1, 0, 0, 0);

        tick(); tick();

        foreach (vt[i]) begin
            rst_n = vt[i].rst_n; ifa.wenable = vt[i].wen; clr = vt[i].clr; thr = vt[i].thr;
            rpnt = '0;
            wd = 8'(i * 7 + 3);
            ifa.wdata_i = wd;
            @(negedge clk);
            chk($sformatf("v%0d.wen", i),   32'(ifa.wenable_o), 32'(vt[i].e_wen));
            chk($sformatf("v%0d.addr", i),  32'(ifa.waddr_o),   32'(vt[i].e_addr));
            chk($sformatf("v%0d.wpnt", i),  32'(wpnt_a),        32'(vt[i].e_wpnt));
            chk($sformatf("v%0d.lvl", i),   32'(lvl_a),         32'(vt[i].e_lvl));
            chk($sformatf("v%0d.full", i),  32'(full_a),        32'(vt[i].e_full));
            chk($sformatf("v%0d.afull", i), 32'(afull_a),       32'(vt[i].e_afull));
            chk($sformatf("v%0d.ovf", i),   32'(ovf_a),         32'(vt[i].e_ovf));
            chk($sformatf("v%0d.cnt", i),   32'(cnt_a),         32'(vt[i].e_cnt));
            chk($sformatf("v%0d.cnt2", i),  32'(cnt_b),         32'(vt[i].e_cnt2));
            chk($sformatf("v%0d.wdata", i), 32'(ifa.wdata_o),   32'(wd));
            tick();
        end
        clr = 1'b0;

        // Wrap-around: writes on 3 of 4 cycles, reads on even cycles while non-empty.
        wp = 4'd8; rp = 4'd0; acc = 0; cyc_n = 0; seen_wrap = 1'b0;
        while (acc < 20 && cyc_n < 200) begin
            we = (cyc_n % 4 != 3);
            ifa.wenable = we; rpnt = rp; thr = 4'd6;
            lvl = wp - rp;
            ewen = we && (lvl != 4'd8);
            @(negedge clk);
            chk("wrap.lvl",   32'(lvl_a),         32'(lvl));
            chk("wrap.full",  32'(full_a),        32'(lvl == 4'd8));
            chk("wrap.afull", 32'(afull_a),       32'(lvl >= 4'd6));
            chk("wrap.wen",   32'(ifa.wenable_o), 32'(ewen));
            chk("wrap.wpnt",  32'(wpnt_a),        32'(wp));
            chk("wrap.addr",  32'(ifa.waddr_o),   32'(wp[2:0]));
            tick();
            if (ewen) begin
                if (wp == 4'd15) seen_wrap = 1'b1;
                wp = wp + 4'd1;
                acc++;
            end
            if (cyc_n % 2 == 0 && lvl != 4'd0) rp = rp + 4'd1;
            cyc_n++;
        end
        chk("wrap.seen", 32'(seen_wrap), 32'd1);
        chk("wrap.count", 32'(acc), 32'd20);

        // Mid-stream reset at level 5 with a write request pending.
        ifa.wenable = 1'b0; rp = wp - 4'd5; rpnt = rp;
        @(negedge clk);
        chk("mrst.lvl5", 32'(lvl_a), 32'd5);
        tick();
        rst_n = 1'b0; ifa.wenable = 1'b1;
        @(negedge clk);
        chk("mrst.wen_in_rst", 32'(ifa.wenable_o), 32'd0);
        tick();
        rst_n = 1'b1; rpnt = '0;
        @(negedge clk);
        chk("mrst.wpnt", 32'(wpnt_a),        32'd0);
        chk("mrst.ovf",  32'(ovf_a),         32'd0);
        chk("mrst.cnt",  32'(cnt_a),         32'd0);
        chk("mrst.addr", 32'(ifa.waddr_o),   32'd0);
        chk("mrst.wen",  32'(ifa.wenable_o), 32'd1);
        tick();

        // Almost-full threshold crossing at 6, then threshold extremes at empty.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("af.lvl%0d", k),   32'(lvl_a),   32'(k));
            chk($sformatf("af.afull%0d", k), 32'(afull_a), 32'd0);
            tick();
        end
        ifa.wenable = 1'b0;
        @(negedge clk);
        chk("af.lvl6",   32'(lvl_a),   32'd6);
        chk("af.afull6", 32'(afull_a), 32'd1);
        tick();
        rpnt = 4'd1;
        @(negedge clk);
        chk("af.lvl5b",   32'(lvl_a),   32'd5);
        chk("af.afull5b", 32'(afull_a), 32'd0);
        tick();
        rpnt = 4'd6; thr = 4'd0;
        @(negedge clk);
        chk("af.thr0_lvl",   32'(lvl_a),   32'd0);
        chk("af.thr0_afull", 32'(afull_a), 32'd1);
        chk("af.thr0_full",  32'(full_a),  32'd0);
        tick();
        thr = 4'd9;
        @(negedge clk);
        chk("af.thr9_afull", 32'(afull_a), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_wrctrl_gen.md
Name: sync_fifo_wrctrl_gen

Overview:
Parametrised write-side controller for the synchronous FIFO, the successor of the current write controller. It uses an (AW+1)-bit wrap-tagged pointer, so all 2^AW entries are usable. It adds fill level, a programmable almost-full flag, and sticky overflow status with a saturating drop counter. There is no clock gating: it drives a write-enable and address into the RAM on the same single clock as the read controller.

Parameters:
- AW, 7, address width; FIFO depth = 2^AW entries.
- DW, 32, data width.
- OCW, 8, width of the overflow drop counter.

Ports:
- wclk_i  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; active low, synchronous.
- wenable  in  1  write request from upstream.
- wdata_i  in  DW  write data.
- rpnt_i  in  AW+1  read pointer from the read controller, with wrap bit; same clock domain.
- afull_thr_i  in  AW+1  almost-full threshold, in entries; quasi-static.
- ovf_clr_i  in  1  clears ovf_o and ovf_cnt_o.
- wenable_o  out  1  RAM write strobe for this cycle.
- wdata_o  out  DW  RAM write data; = wdata_i, pass-through.
- waddr_o  out  AW  RAM write address; = wpnt[AW-1:0].
- wpnt_o  out  AW+1  write pointer, with wrap bit, to the read side.
- full_o  out  1  FIFO holds 2^AW entries.
- afull_o  out  1  level_o >= afull_thr_i.
- level_o  out  AW+1  current occupancy, 0..2^AW.
- ovf_o  out  1  sticky: a write was attempted while full.
- ovf_cnt_o  out  OCW  saturating count of dropped writes.

Behaviour:
- Reset is synchronous and active-low: a rising edge of wclk_i with rst_n=0 sets wpnt=0, ovf_o=0 and ovf_cnt_o=0.
  - While rst_n=0, wenable_o=0.
  - Asserting reset mid-stream discards pointer state immediately at that edge. Resetting the read side together with this block is the integrator's responsibility.
- level_o = (wpnt - rpnt_i) mod 2^(AW+1). Purely combinational from the wpnt register and rpnt_i.
- full_o = (wpnt[AW] != rpnt_i[AW]) && (wpnt[AW-1:0] == rpnt_i[AW-1:0]); equivalently level_o == 2^AW. Combinational, zero latency.
- afull_o = (level_o >= afull_thr_i), unsigned compare.
  - afull_thr_i=0 gives afull_o=1 always.
  - afull_thr_i > 2^AW gives afull_o=0 always.
- Write accept: wenable_o = rst_n & wenable & ~full_o. This is combinational; the RAM captures wdata_o at waddr_o on the same edge.
- Pointer: on an edge with wenable_o=1, wpnt <= wpnt+1, mod 2^(AW+1). The wrap bit toggles when the address rolls over 2^AW-1 -> 0. Otherwise wpnt holds.
- Full and a same-cycle read:
  - full_o is evaluated with the current rpnt_i.
  - A read that advances rpnt_i on the same edge frees a slot only from the next cycle. There is no write-through-full in the same cycle.
- Overflow: on an edge with rst_n=1, wenable=1 and full_o=1:
  - The write is dropped and wpnt is unchanged.
  - ovf_o <= 1.
  - ovf_cnt_o <= ovf_cnt_o+1, saturating at 2^OCW-1.
- Overflow clear: ovf_clr_i=1 on an edge clears ovf_o and ovf_cnt_o.
  - If a drop occurs on the same edge, set wins: ovf_o=1 and ovf_cnt_o=1.
- No state machine beyond the wpnt register, the ovf flag and the counter. All flags track the pointers with 0-cycle combinational latency.

Test Plan:
- AW=3, DW=8. Reset, then 8 back-to-back writes with rpnt_i=0.
  - waddr_o steps 0..7 and level_o steps 0..8.
  - full_o=1 after the 8th edge; wpnt_o=4'b1000.
  - wenable_o=0 afterwards.
- From full, hold wenable=1 for 3 cycles → ovf_o=1, ovf_cnt_o=3, wpnt_o unchanged at 8.
  - Then pulse ovf_clr_i → ovf_o=0 and ovf_cnt_o=0.
  - Pulse ovf_clr_i again with a drop on the same edge → ovf_o=1 and ovf_cnt_o=1.
- Wrap-around: 20 writes interleaved with reads advancing rpnt_i.
  - wpnt_o goes 15→0 with the wrap bit toggling.
  - level_o stays equal to the model count.
  - full_o never asserts when level < 8.
- afull_thr_i=6: level 5→6 gives afull_o 0→1; a read dropping level to 5 clears it.
  - afull_thr_i=0 gives afull_o=1 at empty.
  - afull_thr_i=9 gives afull_o=0 at full.
- OCW=2: 5 writes while full → ovf_cnt_o saturates at 3.
- Mid-stream reset: level=5, drive rst_n=0 for 1 edge with wenable=1.
  - wenable_o=0 during the reset cycle.
  - wpnt_o=0 and ovf_o=0 after the edge.
  - Writes resume the next cycle at waddr_o=0.
